// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: word/address sizes common with the
// datapath, wait-counter width and the responder FSM state encoding.
package mem_responder_pkg;

    localparam int MEM_ADDR_WIDTH = 9;
    localparam int WORD_WIDTH     = 32;
    localparam int CNT_WIDTH      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word RAM. The read register only
// updates on an enabled read, so it holds the last read word between transactions.
module mem_responder_mem_array
    import mem_responder_pkg::*;
#(
    parameter int    ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int    DATA_WIDTH = WORD_WIDTH,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] dout_q;

    // Storage itself is never reset; only the output register is cleared.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) mem[addr_i] <= din_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dout_q <= '0;
        end else if (en_i && !we_i) begin
            dout_q <= mem[addr_i];
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts a level read/write request, waits WAIT_STATES cycles,
// performs the RAM access and pulses mem_ready_o, then waits for the request to drop.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int    ADDR_WIDTH  = MEM_ADDR_WIDTH,
    parameter int    DATA_WIDTH  = WORD_WIDTH,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic                  read_i,
    input  logic                  write_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  mem_ready_o,
    output logic                  busy_o,
    output logic                  req_err_o
);

    localparam logic [CNT_WIDTH-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? CNT_WIDTH'(WAIT_STATES - 1) : '0;
    localparam state_e ACCEPT_NEXT = (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;

    state_e                state_q;
    logic [CNT_WIDTH-1:0]  waitCnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  opWrite_q;
    logic                  memReady_q;
    logic                  busy_q;
    logic                  reqErr_q;
    logic                  ramEn;
    logic                  ramWe;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            waitCnt_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            opWrite_q  <= 1'b0;
            memReady_q <= 1'b0;
            busy_q     <= 1'b0;
            reqErr_q   <= 1'b0;
        end else begin
            memReady_q <= 1'b0;
            reqErr_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (read_i ^ write_i) begin
                        addr_q    <= address_i;
                        wdata_q   <= wdata_i;
                        opWrite_q <= write_i;
                        waitCnt_q <= WAIT_LOAD;
                        busy_q    <= 1'b1;
                        state_q   <= ACCEPT_NEXT;
                    end else if (read_i && write_i) begin
                        reqErr_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (waitCnt_q == '0) begin
                        state_q <= ST_DONE;
                    end else begin
                        waitCnt_q <= waitCnt_q - 1'b1;
                    end
                end
                // The RAM access happens on this edge, so the pulse lines up with rdata.
                ST_DONE: begin
                    memReady_q <= 1'b1;
                    state_q    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!read_i && !write_i) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ramEn = (state_q == ST_DONE);
        ramWe = ramEn && opWrite_q;
    end

    mem_responder_mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (ramEn),
        .we_i  (ramWe),
        .addr_i(addr_q),
        .din_i (wdata_q),
        .dout_o(rdata_o)
    );

    assign mem_ready_o = memReady_q;
    assign busy_o      = busy_q;
    assign req_err_o   = reqErr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and one with none,
// driven from the same request lines so their relative latency can be compared.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  address;
    logic        readReq;
    logic        writeReq;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        memReady;
    logic        busy;
    logic        reqErr;
    logic [31:0] rdata0;
    logic        memReady0;
    logic        busy0;
    logic        reqErr0;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_STATES(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .address_i  (address),
        .read_i     (readReq),
        .write_i    (writeReq),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .mem_ready_o(memReady),
        .busy_o     (busy),
        .req_err_o  (reqErr)
    );

    mem_responder #(.WAIT_STATES(0)) dut0 (
        .clk_i      (clk),
        .rst_i      (rst),
        .address_i  (address),
        .read_i     (readReq),
        .write_i    (writeReq),
        .wdata_i    (wdata),
        .rdata_o    (rdata0),
        .mem_ready_o(memReady0),
        .busy_o     (busy0),
        .req_err_o  (reqErr0)
    );

    // Outputs are sampled 1 time unit after the rising edge, inputs change at that point too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [8:0] a,
                                 input logic [31:0] d);
        readReq  = rd;
        writeReq = wr;
        address  = a;
        wdata    = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Complete request: wait (bounded) for the slow instance's pulse, drop the request, wait for idle.
    task automatic doTransaction(input string tag, input logic rd, input logic wr,
                                 input logic [8:0] a, input logic [31:0] d);
        int cycles;
        applyStimulus(rd, wr, a, d);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!memReady && cycles < 20);
        checkOutput({tag, "_ready"}, {31'b0, memReady}, 32'd1);
        applyStimulus(1'b0, 1'b0, 9'h000, 32'h0);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (busy && cycles < 20);
        checkOutput({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] mar;
        int          pulses;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 9'h000, 32'h0);
        tick();
        tick();
        checkOutput("rst_rdata", rdata, 32'h0);
        checkOutput("rst_ready", {31'b0, memReady}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_err", {31'b0, reqErr}, 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] preload words 0x005, 0x011, 0x020");
        doTransaction("pre5", 1'b0, 1'b1, 9'h005, 32'h590FFFFB);
        doTransaction("pre11", 1'b0, 1'b1, 9'h011, 32'h12345678);
        doTransaction("pre20", 1'b0, 1'b1, 9'h020, 32'h11111111);

        $display("[TB] read latency with two wait states, then held strobe");
        applyStimulus(1'b1, 1'b0, 9'h005, 32'h0);
        tick();
        checkOutput("rd_acc_busy", {31'b0, busy}, 32'd1);
        checkOutput("rd_acc_ready", {31'b0, memReady}, 32'd0);
        tick();
        checkOutput("rd_n1_ready", {31'b0, memReady}, 32'd0);
        checkOutput("rd0_n1_ready", {31'b0, memReady0}, 32'd1);
        checkOutput("rd0_n1_rdata", rdata0, 32'h590FFFFB);
        tick();
        checkOutput("rd_n2_ready", {31'b0, memReady}, 32'd0);
        tick();
        checkOutput("rd_n3_ready", {31'b0, memReady}, 32'd1);
        checkOutput("rd_n3_rdata", rdata, 32'h590FFFFB);
        checkOutput("rd_n3_busy", {31'b0, busy}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (memReady) pulses++;
            checkOutput("hold_busy", {31'b0, busy}, 32'd1);
        end
        checkOutput("hold_pulses", pulses, 32'd0);
        checkOutput("hold_rdata", rdata, 32'h590FFFFB);
        applyStimulus(1'b0, 1'b0, 9'h000, 32'h0);
        tick();
        checkOutput("hold_busy_fall", {31'b0, busy}, 32'd0);
        tick();

        $display("[TB] write then read back, neighbour untouched");
        doTransaction("wr10", 1'b0, 1'b1, 9'h010, 32'h0000001A);
        doTransaction("rd10", 1'b1, 1'b0, 9'h010, 32'h0);
        checkOutput("rd10_data", rdata, 32'h0000001A);
        doTransaction("rd11", 1'b1, 1'b0, 9'h011, 32'h0);
        checkOutput("rd11_data", rdata, 32'h12345678);

        $display("[TB] read and write together");
        applyStimulus(1'b1, 1'b1, 9'h010, 32'hFFFFFFFF);
        tick();
        checkOutput("err_pulse", {31'b0, reqErr}, 32'd1);
        checkOutput("err_busy", {31'b0, busy}, 32'd0);
        applyStimulus(1'b0, 1'b0, 9'h000, 32'h0);
        tick();
        checkOutput("err_fall", {31'b0, reqErr}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (memReady || busy) pulses++;
        end
        checkOutput("err_no_txn", pulses, 32'd0);
        doTransaction("err_rd10", 1'b1, 1'b0, 9'h010, 32'h0);
        checkOutput("err_rd10_data", rdata, 32'h0000001A);

        $display("[TB] reset during a pending write");
        applyStimulus(1'b0, 1'b1, 9'h020, 32'hDEADBEEF);
        tick();
        tick();
        checkOutput("abort_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort_rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_rst_ready", {31'b0, memReady}, 32'd0);
        checkOutput("abort_rst_err", {31'b0, reqErr}, 32'd0);
        checkOutput("abort_rst_rdata", rdata, 32'h0);
        applyStimulus(1'b0, 1'b0, 9'h000, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        doTransaction("abort_rd20", 1'b1, 1'b0, 9'h020, 32'h0);
        checkOutput("abort_rd20_data", rdata, 32'h11111111);

        $display("[TB] zero wait states, wide MAR truncated, early request drop");
        mar = 32'h0000_0205;
        applyStimulus(1'b1, 1'b0, mar[8:0], 32'h0);
        tick();
        checkOutput("ws0_acc_ready", {31'b0, memReady0}, 32'd0);
        checkOutput("ws0_acc_busy", {31'b0, busy0}, 32'd1);
        applyStimulus(1'b0, 1'b0, 9'h000, 32'h0);
        tick();
        checkOutput("ws0_n1_ready", {31'b0, memReady0}, 32'd1);
        checkOutput("ws0_n1_rdata", rdata0, 32'h590FFFFB);
        checkOutput("early_n1_busy", {31'b0, busy}, 32'd1);
        tick();
        checkOutput("ws0_n2_ready", {31'b0, memReady0}, 32'd0);
        checkOutput("ws0_n2_busy", {31'b0, busy0}, 32'd0);
        tick();
        checkOutput("early_n3_ready", {31'b0, memReady}, 32'd1);
        checkOutput("early_n3_rdata", rdata, 32'h590FFFFB);
        tick();
        checkOutput("early_n4_busy", {31'b0, busy}, 32'd0);
        checkOutput("early_n4_ready", {31'b0, memReady}, 32'd0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
